serial_add_sub_unit: RTL and testbench
======================================

Name: serial_add_sub_unit

Overview:
Bit-serial adder/subtractor. It accepts two WIDTH-bit operands and an op select, then resolves one bit per clock through a single full-adder cell (a ripple carry in time). It returns a (WIDTH+1)-bit result over a valid/ready handshake. This is the sequential, subtract-capable counterpart of the combinational carry-ripple adder, and sits in the same datapath where area matters more than latency.

Parameters:
WIDTH, 3, operand width in bits (WIDTH >= 1)
CNT_W, $clog2(WIDTH+1), bit-index counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and op are valid
in_ready  output  1  unit can accept operands
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
op  input  1  0 = add (A+B), 1 = subtract (A-B)
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts result
out  output  WIDTH+1  result; see arithmetic rules
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync deassert by the usual reset scheme): state = IDLE, in_ready = 1, out_valid = 0, out = 0, busy = 0, and all internal registers (operands, carry, counter) = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: capture a, b, op; set carry = op; set bit index = 0; clear the result shift register; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle processes bit i = index, with bb = op ? ~b[i] : b[i]:
    - s = a[i] ^ bb ^ carry
    - carry = majority(a[i], bb, carry)
    - s is written into result bit i.
  - After the bit with index WIDTH-1: out[WIDTH] = op ? ~carry : carry, then go to DONE.
- DONE:
  - out_valid = 1 and out is held stable.
  - On out_ready: out_valid drops on the next edge and the unit returns to IDLE. out keeps its last value until the next result is loaded.
- Latency: out_valid rises exactly WIDTH+1 clock edges after the accepting edge (WIDTH RUN cycles, then DONE). The earliest next accept is one cycle after the out handshake. Throughput is one result per WIDTH+2 cycles when out_ready is held high.
- Arithmetic:
  - Add: out = A + B, where out[WIDTH] is the carry-out.
  - Subtract: out[WIDTH-1:0] = (A - B) mod 2^WIDTH and out[WIDTH] = borrow (1 iff A < B). The unit computes A + ~B + 1 and inverts the final carry.
- Boundary conditions:
  - in_valid while RUN or DONE is ignored, because in_ready = 0. The source must hold its data.
  - out_ready while not DONE has no effect.
  - In DONE, simultaneous out_ready and in_valid: complete the output handshake only. The new operands are accepted in IDLE on the following cycle.
  - out_ready held low: stay in DONE indefinitely with out stable.
  - rst_n asserted mid-RUN or mid-DONE: the transaction is dropped and every output immediately takes its reset value.
  - Operand or op changes on the inputs after the accept edge have no effect on the result.

Decomposition:
- Shared package add_sub_pkg:
  - state enum {IDLE, RUN, DONE}
  - constants OP_ADD = 1'b0 and OP_SUB = 1'b1
- One sub-module: full_adder_bit, a combinational cell with inputs (a, b, cin) and outputs (s, cout), instantiated once in the unit.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles -> in_ready = 1, out_valid = 0, out = 0, busy = 0.
- Add max: a = 7, b = 7, op = 0, out_ready = 1 -> out_valid rises 4 edges after accept, out = 4'd14; in_ready returns high one cycle after the handshake.
- Subtract with borrow: a = 3, b = 5, op = 1 -> out = 4'b1110 (low bits 6, borrow 1). Then a = 5, b = 3, op = 1 -> out = 4'd2. Also a = 4, b = 4, op = 1 -> out = 0.
- Back-pressure: a = 6, b = 1, op = 0, out_ready = 0 for 5 cycles:
  - out stays 4'd7 with out_valid = 1 throughout.
  - in_valid pulsed during this time is not accepted.
  - Raising out_ready completes the transfer.
- Reset mid-operation: accept a = 7, b = 1, assert rst_n = 0 during the second RUN cycle -> outputs return to reset values asynchronously. After release, a = 2, b = 2, op = 0 -> out = 4'd4.
- Randomized: seed = 10, 20 transactions with a, b = $random % 8, op = $random % 2, and random out_ready stalls -> every out matches the reference model, where add gives {carry, sum} and subtract gives {A < B, (A - B) mod 8}.

Source files
------------

// File: rtl/serial_add_sub_unit_pkg.sv
// ============================================================================
// Module   : add_sub_pkg
// Purpose  : Shared state encoding and op codes for the serial add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_add_sub_unit_full_adder_bit.sv
// ============================================================================
// Module   : full_adder_bit
// Purpose  : Single combinational full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_sub_unit.sv
// ============================================================================
// Module   : serial_add_sub_unit
// Purpose  : Bit-serial unsigned adder/subtractor with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub_unit
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             busy
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic               r_carry;
    logic [CNT_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;

    logic               w_bb;
    logic               w_s;
    logic               w_cout;
    logic               w_msb;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_sum_next;

    // Operands shift right each RUN cycle, so the active bit is always bit 0.
    assign w_bb       = (r_op == OP_SUB) ? ~r_b[0] : r_b[0];
    assign w_shift    = {w_s, r_sum};
    assign w_sum_next = w_shift[WIDTH:1];
    assign w_msb      = (r_op == OP_SUB) ? ~w_cout : w_cout;

    full_adder_bit u_fa (
        .a    (r_a[0]),
        .b    (w_bb),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 1'b0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_sum     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_carry  <= op;
                        r_idx    <= '0;
                        r_sum    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_sum   <= w_sum_next;
                    r_idx   <= r_idx + CNT_W'(1);
                    if (r_idx == C_LAST) begin
                        out       <= {w_msb, w_sum_next};
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    // A concurrent in_valid is deliberately not taken here.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub_unit.sv
// ============================================================================
// Module   : tb_serial_add_sub_unit
// Purpose  : Self-checking bench for serial_add_sub_unit (vectors + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub_unit;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs [8];

    serial_add_sub_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: add -> full sum; subtract -> {A<B, (A-B) mod 2^W}.
    function automatic logic [W:0] model(input int ua, input int ub, input logic sub);
        int r;
        if (!sub) r = ua + ub;
        else      r = ((ua < ub) ? (1 << W) : 0) + ((ua - ub + (1 << W)) % (1 << W));
        return r[W:0];
    endfunction

    task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vop);
        int guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a = va; b = vb; op = vop; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~va; b = ~vb; op = ~vop;
    endtask

    // Edges counted from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic transact(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vop, input logic [W:0] exp, input int stall,
                            input bit chk_lat);
        int lat;
        out_ready = 1'b0;
        accept(va, vb, vop);
        wait_valid(lat);
        if (!out_valid) check({name, "_timeout"}, 0, 1);
        if (chk_lat) check({name, "_latency"}, lat, W + 1);
        check({name, "_out"}, out, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, "_stall_hold"}, {out_valid, out}, {1'b1, exp});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_post_hs"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic         rop;

        vecs[0] = '{a: 3'd7, b: 3'd7, op: 1'b0, exp: 4'd14};
        vecs[1] = '{a: 3'd3, b: 3'd5, op: 1'b1, exp: 4'b1110};
        vecs[2] = '{a: 3'd5, b: 3'd3, op: 1'b1, exp: 4'd2};
        vecs[3] = '{a: 3'd4, b: 3'd4, op: 1'b1, exp: 4'd0};
        vecs[4] = '{a: 3'd0, b: 3'd0, op: 1'b0, exp: 4'd0};
        vecs[5] = '{a: 3'd0, b: 3'd1, op: 1'b1, exp: 4'b1111};
        vecs[6] = '{a: 3'd7, b: 3'd0, op: 1'b1, exp: 4'd7};
        vecs[7] = '{a: 3'd1, b: 3'd7, op: 1'b0, exp: 4'd8};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 1'b0;
        tick();
        tick();
        check("reset_state", {in_ready, out_valid, out, busy}, {1'b1, 1'b0, 4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            transact($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 0, 1'b1);

        // Back-pressure with in_valid pulsed while DONE; then coincident handshake.
        accept(3'd6, 3'd1, 1'b0);
        wait_valid(lat);
        check("bp_first", {out_valid, out}, {1'b1, 4'd7});
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); a = 3'd2; b = 3'd3; op = 1'b1;
            tick();
            check("bp_hold", {out_valid, in_ready, busy, out}, {3'b101, 4'd7});
        end
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("bp_coincident", {out_valid, in_ready, busy, out}, {3'b010, 4'd7});
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("bp_idle_stays", {in_ready, busy}, 2'b10);
        out_ready = 1'b1;
        tick();
        check("stray_out_ready", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;

        // Reset asserted during the second RUN cycle.
        accept(3'd7, 3'd1, 1'b0);
        tick();
        check("mid_run_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, out, busy}, {1'b1, 1'b0, 4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        transact("post_reset", 3'd2, 3'd2, 1'b0, 4'd4, 0, 1'b1);

        // Reset while holding a result in DONE.
        accept(3'd5, 3'd6, 1'b0);
        wait_valid(lat);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("done_reset", {in_ready, out_valid, out, busy}, {1'b1, 1'b0, 4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        void'($urandom(10));
        for (int i = 0; i < 20; i++) begin
            ra  = W'($urandom % 8);
            rb  = W'($urandom % 8);
            rop = 1'($urandom % 2);
            transact($sformatf("rand%0d", i), ra, rb, rop, model(int'(ra), int'(rb), rop),
                     int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
